// File: rtl/lsu_mem_ctrl.sv
// Load/store endpoint between EX/MEM and a word-wide req/ack data memory.
// Lane-aligns stores, extends loads, splits misaligned accesses into two beats.
module lsu_mem_ctrl #(
   parameter bit          SPLIT_EN    = 1'b1,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        MemRW,
   input  logic [1:0]  WSel,
   input  logic [2:0]  RSel,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        done,
   output logic        err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

   typedef struct packed {
      logic        load;
      logic        split;
      logic        reject;
      logic [1:0]  off;
      logic [2:0]  rsel;
      logic [3:0]  be_hi;
      logic [31:0] wd_hi;
   } acc_t;

   localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CW-1:0] TLAST = CW'(TIMEOUT_CYC - 1);

   state_t         state, state_n;
   acc_t           acc, acc_n;
   logic [CW-1:0]  tcnt, tcnt_n;
   logic [31:0]    rbuf_lo, rbuf_n;
   logic           mreq_n, we_n, done_n, err_n;
   logic [31:0]    addr_n, wd_n, rdata_n;
   logic [3:0]     be_n;

   logic           st_ok, ld_ok, mis;
   logic [3:0]     smask;
   logic [31:0]    wmask, sh, ld_res;
   logic [7:0]     be8;
   logic [63:0]    wd64, ld64;

   assign req_ready = (state == IDLE);

   // request decode: size mask, lane-shifted enables/data over an 8-byte window
   always_comb begin
      st_ok = MemRW && (WSel != 2'b11);
      ld_ok = !MemRW && (RSel inside {3'b000, 3'b010, 3'b011, 3'b100, 3'b101});
      smask = 4'b0001;
      if (MemRW) begin
         case (WSel)
            2'b01:   smask = 4'b0011;
            2'b10:   smask = 4'b1111;
            default: smask = 4'b0001;
         endcase
      end else begin
         case (RSel)
            3'b010, 3'b101: smask = 4'b0011;
            3'b011:         smask = 4'b1111;
            default:        smask = 4'b0001;
         endcase
      end
      wmask = {{8{smask[3]}}, {8{smask[2]}}, {8{smask[1]}}, {8{smask[0]}}};
      be8   = {4'b0000, smask} << addr[1:0];
      wd64  = {32'h0, wdata & wmask} << {addr[1:0], 3'b000};
      mis   = (be8[7:4] != 4'b0000);
   end

   // second beat's word sits above the captured first word
   always_comb begin
      ld64 = (state == BEAT1) ? {mem_rdata, rbuf_lo} : {32'h0, mem_rdata};
      sh   = 32'(ld64 >> {acc.off, 3'b000});
      case (acc.rsel)
         3'b000:  ld_res = {{24{sh[7]}}, sh[7:0]};
         3'b010:  ld_res = {{16{sh[15]}}, sh[15:0]};
         3'b100:  ld_res = {24'h0, sh[7:0]};
         3'b101:  ld_res = {16'h0, sh[15:0]};
         default: ld_res = sh;
      endcase
   end

   always_comb begin
      state_n = state;
      acc_n   = acc;
      tcnt_n  = tcnt;
      rbuf_n  = rbuf_lo;
      mreq_n  = mem_req;
      we_n    = mem_we;
      addr_n  = mem_addr;
      be_n    = mem_be;
      wd_n    = mem_wdata;
      rdata_n = rdata;
      done_n  = 1'b0;
      err_n   = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid && (st_ok || ld_ok)) begin
               acc_n = '{load: ld_ok, split: mis, reject: mis && !SPLIT_EN,
                         off: addr[1:0], rsel: RSel, be_hi: be8[7:4], wd_hi: wd64[63:32]};
               state_n = BEAT0;
               tcnt_n  = '0;
               if (!(mis && !SPLIT_EN)) begin
                  mreq_n = 1'b1;
                  we_n   = MemRW;
                  addr_n = {addr[31:2], 2'b00};
                  be_n   = be8[3:0];
                  wd_n   = wd64[31:0];
               end
            end
         end
         BEAT0, BEAT1: begin
            if (state == BEAT0 && acc.reject) begin
               state_n = RESP;
               done_n  = 1'b1;
               err_n   = 1'b1;
            end else if (!mem_req) begin
               // idle cycle between beats; raise the second request
               mreq_n = 1'b1;
               tcnt_n = '0;
            end else if (mem_ack) begin
               mreq_n = 1'b0;
               if (state == BEAT0 && acc.split) begin
                  state_n = BEAT1;
                  rbuf_n  = mem_rdata;
                  addr_n  = mem_addr + 32'd4;
                  be_n    = acc.be_hi;
                  wd_n    = acc.wd_hi;
               end else begin
                  state_n = RESP;
                  done_n  = 1'b1;
                  if (acc.load) rdata_n = ld_res;
               end
            end else if (TIMEOUT_CYC != 0 && tcnt == TLAST) begin
               mreq_n  = 1'b0;
               state_n = RESP;
               done_n  = 1'b1;
               err_n   = 1'b1;
            end else begin
               tcnt_n = tcnt + CW'(1);
            end
         end
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= '0;
         tcnt      <= '0;
         rbuf_lo   <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_be    <= '0;
         mem_wdata <= '0;
         rdata     <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_n;
         acc       <= acc_n;
         tcnt      <= tcnt_n;
         rbuf_lo   <= rbuf_n;
         mem_req   <= mreq_n;
         mem_we    <= we_n;
         mem_addr  <= addr_n;
         mem_be    <= be_n;
         mem_wdata <= wd_n;
         rdata     <= rdata_n;
         done      <= done_n;
         err       <= err_n;
      end
   end

endmodule
